// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, op codes and helpers
// for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(
    input logic [2:0] op
  );
    return op[2];
  endfunction

  function automatic logic is_signed_a(
    input logic [2:0] op
  );
    return (op == OP_MULH) ||
           (op == OP_MULHSU) ||
           (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(
    input logic [2:0] op
  );
    return (op == OP_MULH) ||
           (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: 2*XLEN accumulator, one radix-2
// shift-add (mul) or restoring shift-subtract (div) step per enable.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   sub_diff;

  assign hi = acc[2*XLEN-1:XLEN];
  assign lo = acc[XLEN-1:0];

  // Trial add for multiply, trial subtract of the shifted remainder for divide.
  always_comb begin
    add_sum  = {1'b0, hi};
    if (lo[0]) add_sum = {1'b0, hi} + {1'b0, opb_q};
    sub_diff = {hi, lo[XLEN-1]} - {1'b0, opb_q};
  end

  // Load magnitudes, then iterate; product or {remainder, quotient} builds up in acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc   <= {{XLEN{1'b0}}, opa};
      opb_q <= opb;
    end else if (step) begin
      if (!div_mode) begin
        acc <= {add_sum, lo[XLEN-1:1]};
      end else if (!sub_diff[XLEN]) begin
        acc <= {sub_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
        acc <= {hi[XLEN-2:0], lo, 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M MUL/DIV unit with valid/ready handshake.
// Optional MDU_EARLY_OUT_EN: special cases skip CALC and finish early.
module mdu_iterative #(
  parameter int XLEN  = mdu_pkg::XLEN,
  parameter int CNT_W = mdu_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] MDUResult,
  output logic            Zero
);

  import mdu_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              sa_q;
  logic              sb_q;
  logic              div0_q;
  logic              ovf_q;
  logic              mulz_q;
  logic [XLEN-1:0]   src_a_q;

  logic              sa_in;
  logic              sb_in;
  logic              div0_in;
  logic              ovf_in;
  logic              mulz_in;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;

  logic              load;
  logic              step;
  logic              last;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_fix;

  assign in_ready = (state_q == S_IDLE) & ~rst;
  assign last     = (cnt_q == CNT_W'(XLEN-1));

  // Request decode: signs, magnitudes and special-case flags.
  always_comb begin
    sa_in   = is_signed_a(op) & SrcA[XLEN-1];
    sb_in   = is_signed_b(op) & SrcB[XLEN-1];
    abs_a   = sa_in ? -SrcA : SrcA;
    abs_b   = sb_in ? -SrcB : SrcB;
    div0_in = is_div(op) & (SrcB == '0);
    ovf_in  = ((op == OP_DIV) | (op == OP_REM)) &
              (SrcA == MIN_NEG) & (SrcB == '1);
    mulz_in = ~is_div(op) &
              ((SrcA == '0) | (SrcB == '0));
  end

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .div_mode(is_div(op_q)),
    .opa     (abs_a),
    .opb     (abs_b),
    .acc     (acc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes; flush overrides everything.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
`ifdef MDU_EARLY_OUT_EN
            state_d = (div0_in | ovf_in | mulz_in) ?
                      S_FIX : S_CALC;
`else
            state_d = S_CALC;
`endif
          end
        end
        S_CALC: begin
          step = 1'b1;
          if (last) state_d = S_FIX;
        end
        S_FIX:   state_d = S_DONE;
        S_DONE: begin
          if (out_valid & out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sign correction, word select and forced special-case results.
  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc : acc;
    quo  = (sa_q ^ sb_q) ? -acc[XLEN-1:0]
                         : acc[XLEN-1:0];
    rem  = sa_q ? -acc[2*XLEN-1:XLEN]
                : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:    res_fix = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res_fix = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU: begin
        if (div0_q)     res_fix = '1;
        else if (ovf_q) res_fix = MIN_NEG;
        else            res_fix = quo;
      end
      default: begin
        if (div0_q)     res_fix = src_a_q;
        else if (ovf_q) res_fix = '0;
        else            res_fix = rem;
      end
    endcase
    if (mulz_q) res_fix = '0;
  end

  // Request latch, iteration counter, result and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mulz_q    <= 1'b0;
      src_a_q   <= '0;
      out_valid <= 1'b0;
      MDUResult <= '0;
      Zero      <= 1'b1;
    end else if (flush) begin
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            op_q    <= op;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
            mulz_q  <= mulz_in;
            src_a_q <= SrcA;
          end
        end
        S_CALC: cnt_q <= cnt_q + CNT_W'(1);
        S_FIX: begin
          MDUResult <= res_fix;
          Zero      <= (res_fix == '0);
        end
        S_DONE: out_valid <= ~(out_valid & out_ready);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed and random checks of mdu_iterative
// against an arithmetic reference model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] MDUResult;
  logic        Zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_iterative dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .MDUResult(MDUResult),
    .Zero     (Zero)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_mdu(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return 32'h80000000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return 0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
`ifdef MDU_EARLY_OUT_EN
    if (o[2] && b == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) &&
        a == 32'h80000000 && b == 32'hFFFFFFFF)
      return 2;
    if (!o[2] && (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  task automatic issue(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    check($sformatf("in_ready op%0d", o), in_ready, 1);
    in_valid = 1'b1;
    op       = o;
    SrcA     = a;
    SrcB     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    SrcA     = $urandom;
    SrcB     = $urandom;
  endtask

  task automatic wait_result(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int          lat;
    logic [31:0] want;
    string       t;
    want = ref_mdu(o, a, b);
    t    = $sformatf("op%0d a=%h b=%h", o, a, b);
    lat  = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({t, " latency"}, lat, exp_lat(o, a, b));
    check({t, " result"}, MDUResult, want);
    check({t, " zero"}, Zero, want == 0);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release valid/ready",
          {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    issue(o, a, b);
    wait_result(o, a, b);
    release_result();
  endtask

  initial begin
    logic [31:0] held;
    logic        stable;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    SrcA      = '0;
    SrcB      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #12;
    check("reset out_valid", out_valid, 0);
    check("reset result", MDUResult, 0);
    check("reset zero", Zero, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);

    run(3'd0, 32'd7, 32'hFFFFFFFD);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'd4, 32'hFFFFFFF9, 32'd2);
    run(3'd6, 32'hFFFFFFF9, 32'd2);
    run(3'd5, 32'd100, 32'd7);
    run(3'd7, 32'd100, 32'd7);
    run(3'd4, 32'd5, 32'd0);
    run(3'd7, 32'd5, 32'd0);
    run(3'd6, 32'hFFFFFFFB, 32'd0);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF);
    run(3'd0, 32'd0, 32'h12345678);
    run(3'd1, 32'h80000000, 32'h80000000);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h0;
        1:       ra = 32'h80000000;
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run(ro, ra, rb);
    end

    // Stall in DONE with out_ready low.
    issue(3'd5, 32'hDEADBEEF, 32'd3);
    wait_result(3'd5, 32'hDEADBEEF, 32'd3);
    held   = MDUResult;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (MDUResult !== held || !out_valid ||
          in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("stall stable", stable, 1);
    release_result();
    run(3'd0, 32'd11, 32'd13);

    // Reset in the middle of CALC.
    issue(3'd0, 32'd9, 32'd9);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midcalc rst valid", out_valid, 0);
    check("midcalc rst result", MDUResult, 0);
    check("midcalc rst zero", Zero, 1);
    @(negedge clk);
    rst = 1'b0;

    // Flush in CALC together with a new request.
    issue(3'd5, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 3'd0;
    SrcA     = 32'd5;
    SrcB     = 32'd6;
    @(posedge clk);
    #1;
    check("flush calc valid", out_valid, 0);
    check("flush calc idle", in_ready, 1);
    @(posedge clk);
    #1;
    check("flush beats in_valid", in_ready, 1);
    flush    = 1'b0;
    in_valid = 1'b0;
    run(3'd0, 32'd5, 32'd6);

    // Flush while a result is waiting in DONE.
    issue(3'd3, 32'hFFFF0000, 32'h00010000);
    wait_result(3'd3, 32'hFFFF0000, 32'h00010000);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush done valid", out_valid, 0);
    check("flush done idle", in_ready, 1);
    run(3'd6, 32'd17, 32'hFFFFFFFB);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
